// File: rtl/spiflash_responder_if.sv
// Signal bundle of the SPI flash responder: SPI pins, byte-wide memory read port
// and the decoded-command monitor outputs.
interface spiflash_responder_if #(
    parameter int ADDR_BITS = 16
);
    logic                 spi_cs;
    logic                 spi_sclk;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic                 mem_rd;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_rdata;
    logic                 cmd_valid;
    logic [7:0]           cmd_byte;

    // master: flash controller plus the backing memory
    modport master (
        output spi_cs, spi_sclk, spi_mosi, mem_rdata,
        input  spi_miso, mem_rd, mem_addr, cmd_valid, cmd_byte
    );

    modport slave (
        input  spi_cs, spi_sclk, spi_mosi, mem_rdata,
        output spi_miso, mem_rd, mem_addr, cmd_valid, cmd_byte
    );
endinterface

// File: rtl/spiflash_responder.sv
// SPI flash responder (mode 0): oversampled pins, READ (0x03) served from a byte-wide
// synchronous memory port, JEDEC ID (0x9F) served from a constant.
//
// state    | meaning
// S_IDLE   | deselected; waits for cs low (only after cs has been seen high)
// S_CMD    | shifting in the 8-bit command
// S_ADDR   | shifting in the 24-bit address
// S_DATA   | streaming memory bytes out on MISO, prefetching one byte ahead
// S_ID     | streaming JEDEC_ID bytes, then zeros
// S_IGNORE | unknown command; MISO held low until cs rises
module spiflash_responder #(
    parameter int          ADDR_BITS = 16,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic               clk,
    input  logic               reset,
    spiflash_responder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ID,
        S_IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;

    state_t state_q, state_d;

    logic cs_m, cs_s, sclk_m, sclk_s, sclk_q, mosi_m, mosi_s;
    logic rise, fall;
    logic armed;
    logic rd_pend;

    logic [4:0]           bit_cnt;
    logic [6:0]           cmd_sr;
    logic [ADDR_BITS-2:0] addr_sr;
    logic [ADDR_BITS-1:0] ptr;
    logic [7:0]           nxt;
    logic [6:0]           sr;
    logic [1:0]           id_idx;

    logic [7:0]           cmd_next;
    logic [ADDR_BITS-1:0] addr_next;
    logic [7:0]           id_next;

    logic                 miso_q;
    logic                 mem_rd_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic                 cmd_valid_q;
    logic [7:0]           cmd_byte_q;

    assign bus.spi_miso  = miso_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_byte  = cmd_byte_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_m   <= 1'b0;
            cs_s   <= 1'b0;
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_q <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            cs_m   <= bus.spi_cs;
            cs_s   <= cs_m;
            sclk_m <= bus.spi_sclk;
            sclk_s <= sclk_m;
            sclk_q <= sclk_s;
            mosi_m <= bus.spi_mosi;
            mosi_s <= mosi_m;
        end
    end

    assign rise = sclk_s & ~sclk_q;
    assign fall = ~sclk_s & sclk_q;

    // The address shifter keeps only the low ADDR_BITS; upper address bits fall off the top.
    assign cmd_next  = {cmd_sr, mosi_s};
    assign addr_next = {addr_sr, mosi_s};

    always_comb begin
        id_next = 8'h00;
        case (id_idx)
            2'd1:    id_next = JEDEC_ID[15:8];
            2'd2:    id_next = JEDEC_ID[7:0];
            default: id_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (armed && !cs_s) state_d = S_CMD;
            end
            S_CMD: begin
                if (rise && bit_cnt == 5'd7) begin
                    if (cmd_next == CMD_READ)       state_d = S_ADDR;
                    else if (cmd_next == CMD_JEDEC) state_d = S_ID;
                    else                            state_d = S_IGNORE;
                end
            end
            S_ADDR: begin
                if (rise && bit_cnt == 5'd23) state_d = S_DATA;
            end
            default: ;
        endcase
        if (state_q != S_IDLE && cs_s) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed       <= 1'b0;
            rd_pend     <= 1'b0;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            addr_sr     <= '0;
            ptr         <= '0;
            nxt         <= '0;
            sr          <= '0;
            id_idx      <= '0;
            miso_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
        end else begin
            mem_rd_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            rd_pend     <= mem_rd_q;
            if (cs_s) armed <= 1'b1;
            if (rd_pend) nxt <= bus.mem_rdata;

            if (state_q != S_IDLE && cs_s) begin
                bit_cnt <= '0;
                cmd_sr  <= '0;
                addr_sr <= '0;
                sr      <= '0;
                miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        bit_cnt <= '0;
                        cmd_sr  <= '0;
                        miso_q  <= 1'b0;
                    end
                    S_CMD: begin
                        if (rise) begin
                            if (bit_cnt == 5'd7) begin
                                cmd_byte_q  <= cmd_next;
                                cmd_valid_q <= 1'b1;
                                bit_cnt     <= '0;
                                addr_sr     <= '0;
                                if (cmd_next == CMD_JEDEC) begin
                                    nxt    <= JEDEC_ID[23:16];
                                    id_idx <= 2'd1;
                                end
                            end else begin
                                cmd_sr  <= cmd_next[6:0];
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (rise) begin
                            if (bit_cnt == 5'd23) begin
                                mem_rd_q   <= 1'b1;
                                mem_addr_q <= addr_next;
                                ptr        <= addr_next + ADDR_BITS'(1);
                                bit_cnt    <= '0;
                            end else begin
                                addr_sr <= addr_next[ADDR_BITS-2:0];
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_DATA, S_ID: begin
                        if (rise) bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                        if (fall) begin
                            if (bit_cnt[2:0] == 3'd0) begin
                                // Byte boundary: present the prefetched byte, fetch the next one.
                                sr     <= nxt[6:0];
                                miso_q <= nxt[7];
                                if (state_q == S_DATA) begin
                                    mem_rd_q   <= 1'b1;
                                    mem_addr_q <= ptr;
                                    ptr        <= ptr + ADDR_BITS'(1);
                                end else begin
                                    nxt    <= id_next;
                                    id_idx <= (id_idx == 2'd3) ? 2'd3 : id_idx + 2'd1;
                                end
                            end else begin
                                miso_q <= sr[6];
                                sr     <= {sr[5:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        miso_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spiflash_responder.sv
// Directed bench for spiflash_responder: READ, JEDEC ID, address wrap/truncation,
// unknown command, aborted transfer and mid-frame reset.
module tb_spiflash_responder;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic reset;

    spiflash_responder_if #(.ADDR_BITS(16)) bus ();

    spiflash_responder #(.ADDR_BITS(16), .JEDEC_ID(24'hEF4016)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_log [$];
    int          rd_consec = 0;
    logic        rd_prev   = 1'b0;
    int          cmd_cnt   = 0;
    logic [7:0]  cmd_seen  = 8'h00;

    int checks   = 0;
    int failures = 0;

    always @(posedge clk or posedge reset) begin
        if (reset)           bus.mem_rdata <= 8'h00;
        else if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(negedge clk) begin
        if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
        if (bus.mem_rd && rd_prev) rd_consec++;
        rd_prev = bus.mem_rd;
        if (bus.cmd_valid) begin
            cmd_cnt++;
            cmd_seen = bus.cmd_byte;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clocks n bits of tx (MSB first); MISO is sampled where the master samples, at sclk rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            bus.spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_low();
        bus.spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Sends 03 + 24-bit address; returns the OR of everything seen on MISO meanwhile.
    task automatic start_read(input logic [23:0] addr, output logic [7:0] quiet);
        logic [7:0] r;
        quiet = 8'h00;
        cs_low();
        spi_byte(8'h03, r);          quiet |= r;
        spi_byte(addr[23:16], r);    quiet |= r;
        spi_byte(addr[15:8], r);     quiet |= r;
        spi_byte(addr[7:0], r);      quiet |= r;
    endtask

    initial begin
        logic [7:0] rx, acc;
        int rd_base, cmd_base;

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16'h0123] = 8'hA5;
        mem[16'h0124] = 8'h3C;
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        mem[16'h0001] = 8'h33;
        mem[16'h0010] = 8'h96;
        mem[16'h0011] = 8'h69;

        reset        = 1'b1;
        bus.spi_cs   = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_miso",      32'(bus.spi_miso),  32'h0);
        chk("rst_mem_rd",    32'(bus.mem_rd),    32'h0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'h0);
        chk("rst_cmd_byte",  32'(bus.cmd_byte),  32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // READ 0x000123, two bytes
        rd_base = rd_log.size(); cmd_base = cmd_cnt;
        start_read(24'h000123, acc);
        chk("read_hdr_miso", 32'(acc), 32'h0);
        spi_byte(8'h00, rx); chk("read_b0", 32'(rx), 32'hA5);
        spi_byte(8'h00, rx); chk("read_b1", 32'(rx), 32'h3C);
        cs_high();
        chk("read_miso_idle", 32'(bus.spi_miso), 32'h0);
        // the trailing fall after byte 2 prefetches 0x0126 as well
        chk("read_rd_cnt", 32'(rd_log.size() - rd_base), 32'd4);
        chk("read_addr0", 32'(rd_log[rd_base]),     32'h0123);
        chk("read_addr1", 32'(rd_log[rd_base + 1]), 32'h0124);
        chk("read_addr2", 32'(rd_log[rd_base + 2]), 32'h0125);
        chk("read_cmd_cnt", 32'(cmd_cnt - cmd_base), 32'd1);
        chk("read_cmd_byte", 32'(cmd_seen), 32'h03);

        // JEDEC ID, five bytes
        rd_base = rd_log.size(); cmd_base = cmd_cnt;
        cs_low();
        spi_byte(8'h9F, rx); chk("id_cmd_miso", 32'(rx), 32'h0);
        spi_byte(8'h00, rx); chk("id_b0", 32'(rx), 32'hEF);
        spi_byte(8'h00, rx); chk("id_b1", 32'(rx), 32'h40);
        spi_byte(8'h00, rx); chk("id_b2", 32'(rx), 32'h16);
        spi_byte(8'h00, rx); chk("id_b3", 32'(rx), 32'h00);
        spi_byte(8'h00, rx); chk("id_b4", 32'(rx), 32'h00);
        cs_high();
        chk("id_rd_cnt", 32'(rd_log.size() - rd_base), 32'd0);
        chk("id_cmd_cnt", 32'(cmd_cnt - cmd_base), 32'd1);
        chk("id_cmd_byte", 32'(cmd_seen), 32'h9F);

        // Pointer wrap from 0xFFFF
        rd_base = rd_log.size();
        start_read(24'h00FFFF, acc);
        spi_byte(8'h00, rx); chk("wrap_b0", 32'(rx), 32'h11);
        spi_byte(8'h00, rx); chk("wrap_b1", 32'(rx), 32'h22);
        spi_byte(8'h00, rx); chk("wrap_b2", 32'(rx), 32'h33);
        cs_high();
        chk("wrap_addr0", 32'(rd_log[rd_base]),     32'hFFFF);
        chk("wrap_addr1", 32'(rd_log[rd_base + 1]), 32'h0000);
        chk("wrap_addr2", 32'(rd_log[rd_base + 2]), 32'h0001);

        // Upper address bits are truncated
        rd_base = rd_log.size();
        start_read(24'h12FFFF, acc);
        spi_byte(8'h00, rx); chk("trunc_b0", 32'(rx), 32'h11);
        spi_byte(8'h00, rx); chk("trunc_b1", 32'(rx), 32'h22);
        spi_byte(8'h00, rx); chk("trunc_b2", 32'(rx), 32'h33);
        cs_high();
        chk("trunc_addr0", 32'(rd_log[rd_base]), 32'hFFFF);

        // Unknown command 0x5A, 32 more clocks
        rd_base = rd_log.size(); cmd_base = cmd_cnt;
        acc = 8'h00;
        cs_low();
        spi_byte(8'h5A, rx); acc |= rx;
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'hFF, rx);
            acc |= rx;
        end
        cs_high();
        chk("ign_miso", 32'(acc), 32'h0);
        chk("ign_rd_cnt", 32'(rd_log.size() - rd_base), 32'd0);
        chk("ign_cmd_cnt", 32'(cmd_cnt - cmd_base), 32'd1);
        chk("ign_cmd_byte", 32'(cmd_seen), 32'h5A);

        // Abort after 4 bits of the second data byte, then a fresh READ
        start_read(24'h000123, acc);
        spi_byte(8'h00, rx); chk("abort_b0", 32'(rx), 32'hA5);
        spi_bits(8'h00, 4, rx); chk("abort_partial", 32'(rx), 32'h30);
        cs_high();
        chk("abort_miso_idle", 32'(bus.spi_miso), 32'h0);
        start_read(24'h000010, acc);
        chk("abort_hdr_miso", 32'(acc), 32'h0);
        spi_byte(8'h00, rx); chk("abort_new_b0", 32'(rx), 32'h96);
        spi_byte(8'h00, rx); chk("abort_new_b1", 32'(rx), 32'h69);
        cs_high();

        // Reset in the middle of the address phase
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_bits(8'h01, 4, rx);
        reset = 1'b1;
        #1;
        chk("midrst_miso",      32'(bus.spi_miso),  32'h0);
        chk("midrst_cmd_valid", 32'(bus.cmd_valid), 32'h0);
        chk("midrst_mem_rd",    32'(bus.mem_rd),    32'h0);
        chk("midrst_cmd_byte",  32'(bus.cmd_byte),  32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // cs never went high: a complete READ must be ignored
        rd_base = rd_log.size(); cmd_base = cmd_cnt;
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
            spi_byte((k == 0) ? 8'h03 : 8'h00, rx);
            acc |= rx;
        end
        spi_byte(8'h00, rx); acc |= rx;
        chk("unarmed_miso", 32'(acc), 32'h0);
        chk("unarmed_rd_cnt", 32'(rd_log.size() - rd_base), 32'd0);
        chk("unarmed_cmd_cnt", 32'(cmd_cnt - cmd_base), 32'd0);
        cs_high();

        cmd_base = cmd_cnt;
        start_read(24'h000124, acc);
        spi_byte(8'h00, rx); chk("post_rst_b0", 32'(rx), 32'h3C);
        cs_high();
        chk("post_rst_cmd_cnt", 32'(cmd_cnt - cmd_base), 32'd1);
        chk("post_rst_cmd_byte", 32'(cmd_seen), 32'h03);

        chk("rd_never_consec", 32'(rd_consec), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spiflash_responder.md
Name: spiflash_responder

Overview:
- Synthesizable SPI flash device model: the responder end of the SPI flash read protocol issued by the SoC's flash controller (mode 0, single-bit MOSI/MISO).
- Oversamples the SPI pins in the system clock domain and decodes READ (0x03) and JEDEC ID (0x9F).
- Serves READ data from an external byte-wide synchronous memory port.
- Used in FPGA loopback harnesses and simulation benches in place of a physical flash part.

Parameters:
- ADDR_BITS, 16, width of the memory port address; the 24-bit SPI address is truncated to this width (natural wrap).
- JEDEC_ID, 24'h EF4016, 3 bytes returned MSB-first for command 0x9F.

Ports:
- clk  input  1  system clock; must be at least 8x spi_sclk frequency.
- reset  input  1  asynchronous, active-high reset.
- spi_cs  input  1  chip select, active low.
- spi_sclk  input  1  SPI clock, mode 0.
- spi_mosi  input  1  serial data in.
- spi_miso  output  1  serial data out.
- mem_rd  output  1  one-cycle read strobe.
- mem_addr  output  ADDR_BITS  byte address for mem_rd.
- mem_rdata  input  8  read data, valid the cycle after mem_rd.
- cmd_valid  output  1  one-cycle pulse when a command byte completes.
- cmd_byte  output  8  last decoded command byte.

Behaviour:
- Reset: all outputs 0. State IDLE; internal pointers and shifters 0.
- Input sync: spi_cs, spi_sclk and spi_mosi each pass through 2 flops. Edges are detected on the synced sclk: rise = synced high and previous low; fall = the opposite.
- MOSI is sampled on rise. MISO changes only on fall, or on the cycle the DATA state loads its first byte.
- States:
  - IDLE: wait for synced cs low, then go to CMD with bit_cnt=0.
  - CMD: shift 8 MOSI bits MSB-first. On the 8th rise, pulse cmd_valid for 1 clk and set cmd_byte. 0x03 -> ADDR. 0x9F -> ID. Any other value -> IGNORE.
  - ADDR: shift 24 bits MSB-first. On the 24th rise, ptr <= addr, issue mem_rd at ptr, ptr <= ptr+1, then go to DATA with bit_cnt=0.
  - DATA: the cycle after mem_rd, capture mem_rdata into nxt.
    - On fall with bit_cnt==0: sr <= nxt, spi_miso <= nxt[7]. Issue mem_rd at ptr, ptr <= ptr+1.
    - On fall otherwise: shift sr left, spi_miso <= new sr[7].
    - bit_cnt increments mod 8 on each rise.
  - ID: same byte engine as DATA, but nxt is taken from JEDEC_ID bytes [23:16], [15:8], [7:0] in order, then 8'h00 for every later byte. mem_rd stays 0.
  - IGNORE: spi_miso 0; stay until cs high.
- From any non-IDLE state, synced cs high -> IDLE within 1 clk. Partial command, address or data bits are discarded; spi_miso <= 0. No memory side effects.
- spi_miso is 0 in IDLE, CMD, ADDR and IGNORE.
- ptr is ADDR_BITS wide and wraps from all-ones to 0 with no stall.
- mem_rd is never asserted on consecutive cycles. At most one read is issued per 8 SPI bits.
- Timing requirement: a sclk half-period ≥ 4 clk. This guarantees nxt is captured before the fall that consumes it (sync 2 + edge 1 + rdata 1).
- Reset asserted mid-transfer: immediate return to reset values. The transfer restarts only after cs goes high, then low again.
- cs low while reset deasserts: remain in IDLE until cs is seen high, so no partial frame is ever decoded.

Test Plan:
- Memory preloaded with mem[0x0123]=0xA5 and mem[0x0124]=0x3C. Send 03 00 01 23 then clock 16 bits -> MISO bytes A5, 3C. mem_addr sequence is 0x0123, 0x0124, 0x0125. cmd_valid pulses once with cmd_byte=0x03.
- Send 0x9F then clock 40 bits -> MISO bytes EF 40 16 00 00. mem_rd never asserted.
- READ at address 0x00FFFF with ADDR_BITS=16: bytes come from 0xFFFF, then 0x0000, then 0x0001 (wrap). Address 0x12FFFF gives the same sequence (truncation).
- Send unknown command 0x5A plus 32 clocks -> spi_miso stays 0, no mem_rd, cmd_valid pulse with cmd_byte=0x5A.
- Raise cs after 4 bits of the 2nd data byte, then send a new 03 00 00 10 -> first byte out is mem[0x0010]. No stale bits from the aborted transfer.
- Assert reset during the ADDR phase -> spi_miso=0, cmd_valid=0, mem_rd=0 immediately. After release, cs cycling and a new READ return correct data.
